// File: rtl/sound_arbiter_pkg.sv
// Shared constants for the sound arbiter: FSM state codes, jingle ids,
// owner codes and the half-period lookup tables for tones and jingles.
package sound_arbiter_pkg;

    // Arbiter FSM state encodings.
    localparam logic [1:0] SND_IDLE_S = 2'd0;
    localparam logic [1:0] SND_TONE_S = 2'd1;
    localparam logic [1:0] SND_NOTE_S = 2'd2;
    localparam logic [1:0] SND_GAP_S  = 2'd3;

    // Jingle ids; also the bit positions of the pending flags.
    localparam logic [1:0] JNG_START = 2'd0;
    localparam logic [1:0] JNG_LOSE  = 2'd1;
    localparam logic [1:0] JNG_HS    = 2'd2;

    // Speaker owner codes presented on SRC.
    localparam logic [1:0] SRC_NONE   = 2'd0;
    localparam logic [1:0] SRC_TONE   = 2'd1;
    localparam logic [1:0] SRC_JINGLE = 2'd2;

    // Half-periods are 17 bits wide: the last two LOSE notes (70000, 80000)
    // do not fit in 16 bits and would otherwise wrap to a much higher pitch.
    localparam int HP_W = 17;

    // Half-period of the per-colour button tone.
    function automatic logic [HP_W-1:0] tone_hp(input logic [1:0] sel);
        logic [HP_W-1:0] hp;
        case (sel)
            2'd0:    hp = 17'd30120;
            2'd1:    hp = 17'd40323;
            2'd2:    hp = 17'd49603;
            default: hp = 17'd59809;
        endcase
        return hp;
    endfunction

    // Half-period of note nidx of jingle jid.
    function automatic logic [HP_W-1:0] jingle_hp(input logic [1:0] jid,
                                                  input logic [1:0] nidx);
        logic [HP_W-1:0] hp;
        case (jid)
            JNG_LOSE: begin
                case (nidx)
                    2'd0:    hp = 17'd49603;
                    2'd1:    hp = 17'd59809;
                    2'd2:    hp = 17'd70000;
                    default: hp = 17'd80000;
                endcase
            end
            JNG_HS: begin
                case (nidx)
                    2'd0:    hp = 17'd20000;
                    2'd1:    hp = 17'd24000;
                    2'd2:    hp = 17'd20000;
                    default: hp = 17'd15000;
                endcase
            end
            default: begin
                case (nidx)
                    2'd0:    hp = 17'd40323;
                    2'd1:    hp = 17'd30120;
                    2'd2:    hp = 17'd24000;
                    default: hp = 17'd20000;
                endcase
            end
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/sound_arbiter_tone_gen.sv
// Square-wave generator: OUT toggles every HP enabled cycles. Disabling, or
// changing HP, starts a fresh waveform that begins low with the count at 0.
module sound_arbiter_tone_gen
    import sound_arbiter_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic [HP_W-1:0] HP,
    output logic            OUT
);

    logic [HP_W-1:0] count;
    logic [HP_W-1:0] hp_q;
    logic            out_q;
    logic            en_q;
    logic            fresh;
    logic [HP_W-1:0] count_eff;
    logic            out_eff;

    // A waveform restarts on the first enabled cycle or when HP changes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        fresh     = !en_q || (HP != hp_q);
        count_eff = count;
        out_eff   = out_q;
        if (fresh) begin
            count_eff = '0;
            out_eff   = 1'b0;
        end
    end

    // Half-period counter and output flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
            hp_q  <= '0;
            out_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            en_q <= EN;
            hp_q <= HP;
            if (!EN) begin
                count <= '0;
                out_q <= 1'b0;
            end else if (count_eff == HP - 17'd1) begin
                count <= '0;
                out_q <= ~out_eff;
            end else begin
                count <= count_eff + 17'd1;
                out_q <= out_eff;
            end
        end
    end

    // Silence immediately when disabled and at the first cycle of a new waveform.
    assign OUT = EN && out_q && !fresh;

endmodule

// File: rtl/sound_arbiter.sv
// Speaker arbiter: latches jingle event pulses, picks the owner of the piezo
// by fixed priority (HS > LOSE > START > colour tone), sequences the four
// notes of a jingle with note/gap timers and drives the tone generator.
module sound_arbiter
    import sound_arbiter_pkg::*;
#(
    parameter int unsigned NOTE_CYCLES = 3_125_000,
    parameter int unsigned GAP_CYCLES  = 625_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TONE_REQ,
    input  logic [1:0] TONE_SEL,
    input  logic       EVT_START,
    input  logic       EVT_LOSE,
    input  logic       EVT_HS,
    input  logic       MUTE,
    output logic       SPK,
    output logic       BUSY,
    output logic [1:0] SRC
);

    // Timers count down to zero, so a phase of N cycles loads N-1.
    localparam logic [24:0] NOTE_LOAD = 25'(NOTE_CYCLES - 1);
    localparam logic [24:0] GAP_LOAD  = 25'(GAP_CYCLES - 1);

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [2:0]      pend;        // pending flags, bit index = jingle id
    logic [1:0]      jid;
    logic [1:0]      nidx;
    logic [24:0]     timer;
    logic            any_pend;
    logic            timer_done;
    logic            launch;
    logic [1:0]      launch_id;
    logic [2:0]      launch_mask;
    logic            gen_en;
    logic [HP_W-1:0] gen_hp;
    logic            gen_out;

    assign any_pend   = |pend;
    assign timer_done = (timer == 25'd0);
    assign launch_id  = pend[JNG_HS]   ? JNG_HS   :
                        pend[JNG_LOSE] ? JNG_LOSE : JNG_START;

    // Next-state and jingle-launch decision.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            SND_IDLE_S: begin
                if (any_pend) begin
                    state_next = SND_NOTE_S;
                    launch     = 1'b1;
                end else if (TONE_REQ) begin
                    state_next = SND_TONE_S;
                end
            end
            SND_TONE_S: begin
                if (any_pend) begin
                    state_next = SND_NOTE_S;
                    launch     = 1'b1;
                end else if (!TONE_REQ) begin
                    state_next = SND_IDLE_S;
                end
            end
            SND_NOTE_S: begin
                if (timer_done) state_next = SND_GAP_S;
            end
            default: begin
                if (timer_done) begin
                    if (nidx != 2'd3) begin
                        state_next = SND_NOTE_S;
                    end else if (any_pend) begin
                        state_next = SND_NOTE_S;
                        launch     = 1'b1;
                    end else begin
                        state_next = SND_IDLE_S;
                    end
                end
            end
        endcase
        launch_mask = launch ? (3'b001 << launch_id) : 3'b000;
    end

    // FSM, pending flags, jingle pointer and phase timer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= SND_IDLE_S;
            pend  <= 3'b000;
            jid   <= JNG_START;
            nidx  <= 2'd0;
            timer <= 25'd0;
        end else begin
            state <= state_next;
            // A pulse in the launch cycle re-arms the flag being cleared.
            pend  <= (pend & ~launch_mask) | {EVT_HS, EVT_LOSE, EVT_START};
            if (launch) begin
                jid  <= launch_id;
                nidx <= 2'd0;
            end else if (state == SND_GAP_S && timer_done) begin
                nidx <= nidx + 2'd1;
            end
            if (state_next != state) begin
                if (state_next == SND_NOTE_S)     timer <= NOTE_LOAD;
                else if (state_next == SND_GAP_S) timer <= GAP_LOAD;
                else                              timer <= 25'd0;
            end else if (!timer_done) begin
                timer <= timer - 25'd1;
            end
        end
    end

    // Owner / busy flags and tone-generator control from the current state.
    always_comb begin
        SRC    = SRC_NONE;
        BUSY   = 1'b0;
        gen_en = 1'b0;
        gen_hp = tone_hp(TONE_SEL);
        case (state)
            SND_TONE_S: begin
                SRC    = SRC_TONE;
                gen_en = 1'b1;
            end
            SND_NOTE_S: begin
                SRC    = SRC_JINGLE;
                BUSY   = 1'b1;
                gen_en = 1'b1;
                gen_hp = jingle_hp(jid, nidx);
            end
            SND_GAP_S: begin
                SRC  = SRC_JINGLE;
                BUSY = 1'b1;
            end
            default: ;
        endcase
    end

    sound_arbiter_tone_gen u_tone_gen (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (gen_en),
        .HP    (gen_hp),
        .OUT   (gen_out)
    );

    assign SPK = gen_out & ~MUTE;

endmodule

// File: tb/tb_sound_arbiter.sv
// Scoreboard bench for sound_arbiter. A behavioural model, run on the falling
// edge, pushes the expected {SPK,BUSY,SRC} of each cycle into a queue; an
// independent monitor pops and compares against the DUT just afterwards.
module tb_sound_arbiter;

    localparam int N  = 100;
    localparam int G  = 20;
    localparam int JL = 4 * (N + G);

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       TONE_REQ = 1'b0;
    logic [1:0] TONE_SEL = 2'd0;
    logic       EVT_START = 1'b0;
    logic       EVT_LOSE = 1'b0;
    logic       EVT_HS = 1'b0;
    logic       MUTE = 1'b0;
    logic       SPK;
    logic       BUSY;
    logic [1:0] SRC;

    sound_arbiter #(.NOTE_CYCLES(N), .GAP_CYCLES(G)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .TONE_REQ  (TONE_REQ),
        .TONE_SEL  (TONE_SEL),
        .EVT_START (EVT_START),
        .EVT_LOSE  (EVT_LOSE),
        .EVT_HS    (EVT_HS),
        .MUTE      (MUTE),
        .SPK       (SPK),
        .BUSY      (BUSY),
        .SRC       (SRC)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       spk;
        logic       busy;
        logic [1:0] src;
    } exp_t;

    exp_t  exp_q[$];
    bit    armed = 1'b0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    string phase = "reset";

    int tone_tbl[4]   = '{30120, 40323, 49603, 59809};
    int jng_tbl[3][4] = '{'{40323, 30120, 24000, 20000},
                          '{49603, 59809, 70000, 80000},
                          '{20000, 24000, 20000, 15000}};

    // Reference model state: pending requests, the jingle being played as a
    // flat cycle position, whether the colour tone owns the speaker, and the
    // current square-wave segment (constant half-period, continuously enabled).
    bit pend[3];
    bit j_on, t_on;
    int j_id, j_pos;
    bit g_en_prev;
    int g_hp, g_age;

    always @(negedge CLK) begin
        exp_t e;
        bit   en, any, launch;
        int   hp, pick;
        e = '0;
        if (!RST_N) begin
            pend = '{0, 0, 0};
            j_on = 0; t_on = 0; j_id = 0; j_pos = 0;
            g_en_prev = 0; g_hp = 0; g_age = 0;
        end else begin
            en = 0;
            hp = 0;
            if (j_on) begin
                e.src  = 2'd2;
                e.busy = 1'b1;
                if (j_pos % (N + G) < N) begin
                    en = 1;
                    hp = jng_tbl[j_id][j_pos / (N + G)];
                end
            end else if (t_on) begin
                e.src = 2'd1;
                en    = 1;
                hp    = tone_tbl[TONE_SEL];
            end
            if (en) begin
                if (!g_en_prev || hp != g_hp) begin
                    g_hp  = hp;
                    g_age = 0;
                end
                e.spk = ((g_age / hp) % 2 == 1) && !MUTE;
                g_age++;
            end
            g_en_prev = en;

            any    = pend[0] || pend[1] || pend[2];
            pick   = pend[2] ? 2 : (pend[1] ? 1 : 0);
            launch = 0;
            if (j_on) begin
                j_pos++;
                if (j_pos == JL) begin
                    j_on = 0;
                    if (any) launch = 1;
                end
            end else if (t_on) begin
                if (any) launch = 1;
                else if (!TONE_REQ) t_on = 0;
            end else begin
                if (any) launch = 1;
                else if (TONE_REQ) t_on = 1;
            end
            if (launch) begin
                j_on = 1; t_on = 0; j_id = pick; j_pos = 0; pend[pick] = 0;
            end
            if (EVT_START) pend[0] = 1;
            if (EVT_LOSE)  pend[1] = 1;
            if (EVT_HS)    pend[2] = 1;
        end
        exp_q.push_back(e);
        armed = 1'b1;
    end

    // Monitor: compare the DUT against the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        #1;
        cyc++;
        if (armed) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty cycle=%0d phase=%s", cyc, phase);
            end else begin
                e = exp_q.pop_front();
                if ({SPK, BUSY, SRC} !== {e.spk, e.busy, e.src}) begin
                    n_bad++;
                    $display("FAIL %s cycle=%0d got spk=%b busy=%b src=%0d want spk=%b busy=%b src=%0d",
                             phase, cyc, SPK, BUSY, SRC, e.spk, e.busy, e.src);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic pulse(input int which);
        if (which == 0) EVT_START = 1'b1;
        if (which == 1) EVT_LOSE  = 1'b1;
        if (which == 2) EVT_HS    = 1'b1;
        step(1);
        EVT_START = 1'b0;
        EVT_LOSE  = 1'b0;
        EVT_HS    = 1'b0;
    endtask

    initial begin
        step(4);
        RST_N = 1'b1;
        step(3);

        // Lowest-pitch-period tone held past one full high half-period,
        // with a mute window while SPK is high.
        phase = "tone";
        TONE_SEL = 2'd0;
        TONE_REQ = 1'b1;
        step(35000);
        phase = "tone_mute";
        MUTE = 1'b1;
        step(50);
        MUTE = 1'b0;
        phase = "tone";
        step(26000);
        phase = "tone_drop";
        TONE_REQ = 1'b0;
        step(5);

        phase = "tone_sel_change";
        TONE_SEL = 2'd2;
        TONE_REQ = 1'b1;
        step(100);
        TONE_SEL = 2'd3;
        step(100);
        TONE_REQ = 1'b0;
        step(5);

        phase = "start_jingle";
        pulse(0);
        step(JL + 20);

        phase = "preempt";
        TONE_SEL = 2'd1;
        TONE_REQ = 1'b1;
        step(50);
        pulse(1);
        step(JL + 50);
        TONE_REQ = 1'b0;
        step(5);

        phase = "hs_then_lose";
        EVT_HS   = 1'b1;
        EVT_LOSE = 1'b1;
        step(1);
        EVT_HS   = 1'b0;
        EVT_LOSE = 1'b0;
        step(2 * JL + 20);

        phase = "start_queue";
        pulse(0);
        step(139);
        pulse(0);
        step(59);
        pulse(0);
        step(2 * JL + 20);

        phase = "jingle_mute";
        pulse(2);
        step(50);
        MUTE = 1'b1;
        step(200);
        MUTE = 1'b0;
        step(300);

        phase = "reset_mid_note";
        pulse(0);
        step(30);
        pulse(1);
        step(10);
        RST_N = 1'b0;
        step(3);
        RST_N = 1'b1;
        step(JL + 20);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            EVT_START = ($urandom_range(0, 299) == 0);
            EVT_LOSE  = ($urandom_range(0, 299) == 0);
            EVT_HS    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0)  TONE_REQ = ~TONE_REQ;
            if ($urandom_range(0, 49) == 0)  TONE_SEL = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) MUTE = ~MUTE;
            step(1);
        end
        EVT_START = 1'b0;
        EVT_LOSE  = 1'b0;
        EVT_HS    = 1'b0;
        MUTE      = 1'b0;
        TONE_REQ  = 1'b0;
        step(5);

        @(negedge CLK);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
